// File: rtl/lohi_issue_ctrl_if.sv
// Pipeline-side bundle of the HI/LO issue controller.
//   master : pipeline, drives the op request and observes stall / MF read data
//   slave  : lohi_issue_ctrl
// Signals:
//   op_valid, op_code, rs_data, rt_data : HI/LO-class op request
//   stall                               : pipeline must hold the current op
//   rd_data, rd_valid                   : MFHI/MFLO result
interface lohi_issue_ctrl_if #(
  parameter int unsigned OP_WIDTH = 3
);
  logic                op_valid;
  logic [OP_WIDTH-1:0] op_code;
  logic [31:0]         rs_data;
  logic [31:0]         rt_data;
  logic                stall;
  logic [31:0]         rd_data;
  logic                rd_valid;

  modport master (
    output op_valid, op_code, rs_data, rt_data,
    input  stall, rd_data, rd_valid
  );

  modport slave (
    input  op_valid, op_code, rs_data, rt_data,
    output stall, rd_data, rd_valid
  );
endinterface

// File: rtl/lohi_issue_ctrl.sv
// Execute-stage controller in front of the multiplier / HI-LO wrapper.
// Decodes MULT/MULTU/MFHI/MFLO/MTHI/MTLO, hands operand magnitudes to the
// unsigned wrapper, sign-corrects the captured product into HI/LO and stalls
// HI/LO-class ops while a multiply is in flight.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pipe (slave)          : op request, stall, MF read data (stall/rd_* combinational)
//   busy                  : multiply in flight
//   err_timeout           : sticky, a multiply was aborted after TIMEOUT_CYCLES
//   mul_opr1, mul_opr2    : registered unsigned operands to the wrapper
//   mul_result, mul_ready : wrapper product and its match-current-operands flag
module lohi_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned OP_WIDTH       = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lohi_issue_ctrl_if.slave       pipe,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [31:0]            mul_opr1,
  output logic [31:0]            mul_opr2,
  input  logic [63:0]            mul_result,
  input  logic                   mul_ready
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULTU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MFHI  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_MFLO  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_MTHI  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_MTLO  = OP_WIDTH'(6);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        hi, hi_nxt;
  logic [31:0]        lo, lo_nxt;
  logic [31:0]        opr1_nxt, opr2_nxt;
  logic               neg_flag, neg_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               err_nxt;
  logic               hilo_op;
  logic               stall_c;
  logic               rd_valid_c;
  logic [31:0]        rd_data_c;

  // Two's complement magnitude; 0x80000000 stays 0x80000000 (2^31 unsigned).
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Every defined op except NONE/reserved competes for HI/LO.
  always_comb begin
    hilo_op = 1'b0;
    case (pipe.op_code)
      OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: hilo_op = 1'b1;
      default:                                              hilo_op = 1'b0;
    endcase
  end

  // Next-state, datapath and pipeline-facing outputs.
  always_comb begin
    state_nxt  = state;
    hi_nxt     = hi;
    lo_nxt     = lo;
    opr1_nxt   = mul_opr1;
    opr2_nxt   = mul_opr2;
    neg_nxt    = neg_flag;
    cnt_nxt    = cnt;
    err_nxt    = err_timeout;
    rd_valid_c = 1'b0;
    rd_data_c  = 32'd0;
    stall_c    = pipe.op_valid & (state == MUL_WAIT) & hilo_op;

    case (state)
      IDLE: begin
        if (pipe.op_valid) begin
          case (pipe.op_code)
            OP_MULT, OP_MULTU: begin
              if (pipe.op_code == OP_MULT) begin
                opr1_nxt = mag32(pipe.rs_data);
                opr2_nxt = mag32(pipe.rt_data);
                neg_nxt  = pipe.rs_data[31] ^ pipe.rt_data[31];
              end else begin
                opr1_nxt = pipe.rs_data;
                opr2_nxt = pipe.rt_data;
                neg_nxt  = 1'b0;
              end
              cnt_nxt   = '0;
              state_nxt = MUL_WAIT;
            end
            OP_MTHI: hi_nxt = pipe.rs_data;
            OP_MTLO: lo_nxt = pipe.rs_data;
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // First wait cycle: wrapper has not yet seen the new operands.
        if ((cnt != '0) && mul_ready) begin
          {hi_nxt, lo_nxt} = neg_flag ? (~mul_result + 64'd1) : mul_result;
          state_nxt        = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reads are served only when not stalled and never while reset is held.
    if (rst_n && pipe.op_valid && !stall_c) begin
      if (pipe.op_code == OP_MFHI) begin
        rd_valid_c = 1'b1;
        rd_data_c  = hi;
      end else if (pipe.op_code == OP_MFLO) begin
        rd_valid_c = 1'b1;
        rd_data_c  = lo;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= 32'd0;
      lo          <= 32'd0;
      mul_opr1    <= 32'd0;
      mul_opr2    <= 32'd0;
      neg_flag    <= 1'b0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      hi          <= hi_nxt;
      lo          <= lo_nxt;
      mul_opr1    <= opr1_nxt;
      mul_opr2    <= opr2_nxt;
      neg_flag    <= neg_nxt;
      cnt         <= cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  assign busy          = (state == MUL_WAIT);
  assign pipe.stall    = stall_c;
  assign pipe.rd_valid = rd_valid_c;
  assign pipe.rd_data  = rd_data_c;

endmodule
